// File: rtl/op_exec_pkg.sv
// Shared types for the 8-bit immediate execute stage: opcodes, register names
// and the execute FSM states.
package op_exec_pkg;

    typedef enum logic [2:0] {
        ADDI = 3'd0,
        SUBI = 3'd1,
        ANDI = 3'd2,
        XORI = 3'd3,
        JMP  = 3'd4,
        JMPC = 3'd5,
        CALL = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        REG0 = 2'd0,
        REG1 = 2'd1,
        REG2 = 2'd2,
        REG3 = 2'd3
    } reg_t;

    localparam logic [2:0] OP_RET = 3'd7;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/op_call_stack.sv
// Return-address stack: a fill pointer plus an entry array. Push on full and
// pop on empty are ignored here; the execute stage turns them into faults.
module op_call_stack
    import op_exec_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [AW:0]     ptr_q, ptr_d;
    logic [PC_W-1:0] mem_q [STACK_DEPTH];
    logic [AW-1:0]   top_idx;

    assign full    = (ptr_q == (AW+1)'(STACK_DEPTH));
    assign empty   = (ptr_q == '0);
    assign top_idx = AW'(ptr_q - 1'b1);
    assign dout    = mem_q[top_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (push && !full)
            ptr_d = ptr_q + 1'b1;
        else if (pop && !empty)
            ptr_d = ptr_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    // Entry contents need no reset; only the pointer defines what is live.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem_q[ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/op_exec_unit.sv
// Execute stage: register file, carry, PC and call stack updated at the accept
// edge, with a registered one-cycle result pulse. OP_EXEC_RET_EN enables RET.
module op_exec_unit
    import op_exec_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [1:0]      in_rd,
    input  logic [7:0]      in_imm,
    output logic            out_valid,
    output logic [7:0]      out_rd_val,
    output logic [PC_W-1:0] out_pc,
    output logic            out_carry,
    output logic            err
);
    state_t          state_q;
    logic [3:0][7:0] regs_q, regs_d;
    logic            carry_q, carry_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, imm_pc;
    logic            err_d, halt_d, push, pop;
    logic [7:0]      rd_old;
    logic [8:0]      sum;
    logic            accept;
    logic [PC_W-1:0] stk_dout;
    logic            stk_full, stk_empty;
    op_t             op;

    assign op       = op_t'(in_op);
    assign in_ready = rst_n && (state_q == RUN);
    assign accept   = in_valid && in_ready;
    assign pc_inc   = pc_q + 1'b1;
    assign imm_pc   = PC_W'(in_imm);
    assign rd_old   = regs_q[in_rd];

    always_comb begin
        regs_d  = regs_q;
        carry_d = carry_q;
        pc_d    = pc_inc;
        err_d   = 1'b0;
        halt_d  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        sum     = '0;
        case (op)
            ADDI: begin
                sum           = {1'b0, rd_old} + {1'b0, in_imm};
                regs_d[in_rd] = sum[7:0];
                carry_d       = sum[8];
            end
            SUBI: begin
                // The wrapped ninth bit of the difference is the borrow.
                sum           = {1'b0, rd_old} - {1'b0, in_imm};
                regs_d[in_rd] = sum[7:0];
                carry_d       = sum[8];
            end
            ANDI: regs_d[in_rd] = rd_old & in_imm;
            XORI: regs_d[in_rd] = rd_old ^ in_imm;
            JMP:  pc_d = imm_pc;
            JMPC: if (carry_q) pc_d = imm_pc;
            CALL: begin
                if (stk_full) begin
                    err_d  = 1'b1;
                    halt_d = 1'b1;
                    pc_d   = pc_q;
                end else begin
                    push = accept;
                    pc_d = imm_pc;
                end
            end
            default: begin
`ifdef OP_EXEC_RET_EN
                if (stk_empty) begin
                    err_d  = 1'b1;
                    halt_d = 1'b1;
                    pc_d   = pc_q;
                end else begin
                    pop  = accept;
                    pc_d = stk_dout;
                end
`else
                err_d = 1'b1;
`endif
            end
        endcase
    end

`ifndef OP_EXEC_RET_EN
    logic unused_stk;
    assign unused_stk = ^{stk_dout, stk_empty};
`endif

    op_call_stack #(
        .STACK_DEPTH(STACK_DEPTH),
        .PC_W       (PC_W)
    ) u_stack (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (pc_inc),
        .dout (stk_dout),
        .full (stk_full),
        .empty(stk_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            regs_q     <= '0;
            carry_q    <= 1'b0;
            pc_q       <= '0;
            out_valid  <= 1'b0;
            out_rd_val <= '0;
            out_pc     <= '0;
            out_carry  <= 1'b0;
            err        <= 1'b0;
        end else begin
            out_valid <= accept;
            err       <= accept && err_d;
            if (accept) begin
                regs_q     <= regs_d;
                carry_q    <= carry_d;
                pc_q       <= pc_d;
                out_rd_val <= regs_d[in_rd];
                out_pc     <= pc_d;
                out_carry  <= carry_d;
                if (halt_d)
                    state_q <= HALT;
            end
        end
    end

endmodule

// File: tb/tb_op_exec_unit.sv
// Self-checking bench for op_exec_unit against an instruction-level reference
// model (register array, carry, PC and a queue as the call stack).
module tb_op_exec_unit;

    localparam int DEPTH = 4;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [1:0]    in_rd = '0;
    logic [7:0]    in_imm = '0;
    logic          out_valid;
    logic [7:0]    out_rd_val;
    logic [PW-1:0] out_pc;
    logic          out_carry;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_regs [4];
    int m_carry, m_pc, m_halt;
    int m_stack [$];
    int e_rd, e_pc, e_carry;

    always #5 clk = ~clk;

    op_exec_unit #(.STACK_DEPTH(DEPTH), .PC_W(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_rd_val(out_rd_val),
        .out_pc    (out_pc),
        .out_carry (out_carry),
        .err       (err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_carry = 0; m_pc = 0; m_halt = 0;
        m_stack.delete();
        e_rd = 0; e_pc = 0; e_carry = 0;
    endfunction

    // Returns the expected err bit for one accepted instruction.
    function automatic int model_step(input int op, input int rd, input int imm);
        int e = 0;
        int pmask = (1 << PW) - 1;
        int nxt = (m_pc + 1) & pmask;
        case (op)
            0: begin
                m_carry = (m_regs[rd] + imm) > 255;
                m_regs[rd] = (m_regs[rd] + imm) % 256;
                m_pc = nxt;
            end
            1: begin
                m_carry = m_regs[rd] < imm;
                m_regs[rd] = (m_regs[rd] - imm + 256) % 256;
                m_pc = nxt;
            end
            2: begin m_regs[rd] = m_regs[rd] & imm; m_pc = nxt; end
            3: begin m_regs[rd] = m_regs[rd] ^ imm; m_pc = nxt; end
            4: m_pc = imm & pmask;
            5: m_pc = m_carry ? (imm & pmask) : nxt;
            6: begin
                if (m_stack.size() == DEPTH) begin e = 1; m_halt = 1; end
                else begin m_stack.push_back(nxt); m_pc = imm & pmask; end
            end
            default: begin
`ifdef OP_EXEC_RET_EN
                if (m_stack.size() == 0) begin e = 1; m_halt = 1; end
                else m_pc = m_stack.pop_back();
`else
                e = 1;
                m_pc = nxt;
`endif
            end
        endcase
        return e;
    endfunction

    task automatic exec(input int op, input int rd, input int imm, input bit v);
        int  e_err;
        bit  acc;
        @(negedge clk);
        check("in_ready", int'(in_ready), m_halt ? 0 : 1);
        in_valid = v; in_op = op[2:0]; in_rd = rd[1:0]; in_imm = imm[7:0];
        acc = v && !m_halt;
        e_err = 0;
        if (acc) begin
            e_err   = model_step(op, rd, imm);
            e_rd    = m_regs[rd];
            e_pc    = m_pc;
            e_carry = m_carry;
        end
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(acc));
        check("err", int'(err), e_err);
        check("out_rd_val", int'(out_rd_val), e_rd);
        check("out_pc", int'(out_pc), e_pc);
        check("out_carry", int'(out_carry), e_carry);
    endtask

    task automatic do_reset(input bit with_valid);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = with_valid; in_op = 3'd0; in_rd = 2'd0; in_imm = 8'h11;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_rd_val", int'(out_rd_val), 0);
        check("rst_pc", int'(out_pc), 0);
        check("rst_carry", int'(out_carry), 0);
        check("rst_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset(1'b0);

        // ADDI carry chain
        exec(0, 0, 8'h05, 1);
        check("addi1_val", int'(out_rd_val), 8'h05);
        exec(0, 0, 8'hFF, 1);
        check("addi2_val", int'(out_rd_val), 8'h04);
        check("addi2_carry", int'(out_carry), 1);
        check("addi2_pc", int'(out_pc), 2);

        // Borrow and conditional jumps
        exec(1, 1, 8'h01, 1);
        check("subi_val", int'(out_rd_val), 8'hFF);
        exec(5, 0, 8'h40, 1);
        check("jmpc_taken", int'(out_pc), 8'h40);
        exec(1, 1, 8'h0F, 1);
        check("subi2_val", int'(out_rd_val), 8'hF0);
        exec(5, 0, 8'h10, 1);
        check("jmpc_not_taken", int'(out_pc), 8'h42);

        // Bitwise sweep
        for (int r = 0; r < 4; r++) begin
            exec(2, r, 8'hAA, 1);
            exec(3, r, 8'h55, 1);
            exec(3, r, 8'hAA, 1);
        end

        // Randomized stream with idle gaps; no CALL so the unit stays in RUN
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 7);
            if (op == 6) op = 4;
`ifdef OP_EXEC_RET_EN
            if (op == 7) op = 5;
`endif
            exec(op, $urandom_range(0, 3), $urandom_range(0, 255), ($urandom_range(0, 3) != 0));
        end

`ifndef OP_EXEC_RET_EN
        // Illegal opcode: err, pc advances, unit keeps running
        exec(7, 2, 8'h33, 1);
        check("op7_err", int'(err), 1);
        exec(0, 2, 8'h01, 1);
        check("op7_still_ready", int'(out_valid), 1);
`else
        do_reset(1'b0);
        exec(0, 0, 1, 1); exec(0, 0, 1, 1); exec(0, 0, 1, 1);
        exec(6, 0, 8'h20, 1);
        check("call_pc", int'(out_pc), 8'h20);
        exec(7, 0, 0, 1);
        check("ret_pc", int'(out_pc), 8'h04);
        exec(7, 0, 0, 1);
        check("ret_empty_err", int'(err), 1);
        exec(0, 0, 1, 1);
        check("ret_halt_no_valid", int'(out_valid), 0);
`endif

        // Reset in the middle of a back-to-back stream
        do_reset(1'b0);
        exec(0, 0, 8'h30, 1);
        exec(0, 2, 8'h12, 1);
        do_reset(1'b1);
        exec(0, 0, 8'h03, 1);
        check("post_rst_val", int'(out_rd_val), 8'h03);
        check("post_rst_pc", int'(out_pc), 1);

        // Stack overflow halts the unit
        for (int i = 0; i <= DEPTH; i++)
            exec(6, 0, 8'h80 + i, 1);
        check("ovf_err", int'(err), 1);
        check("ovf_pc", int'(out_pc), 8'h80 + DEPTH - 1);
        for (int i = 0; i < 4; i++)
            exec(0, 1, 8'h01, 1);
        check("halt_no_valid", int'(out_valid), 0);
        check("halt_ready", int'(in_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
